dmem_arbiter: RTL

- Shares the single-port data memory between two requesters:
  - the core MEM stage (load/store);
  - an external master (debug/DMA) port.
- Sits between the MEM stage's memory interface (we/address/write-data/read-data) and the data memory macro.
- Sequences each access over a fixed number of memory wait states.
- Stalls the pipeline while the core's access is pending.
- Core has priority, with an anti-starvation bound for the external port.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arb_wait_cnt.sv | 38 +++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// FSM state encodings, parameter defaults, counter width helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_EXT  = 2'd2
  } arb_state_t;

  localparam int DEF_WAIT_CYCLES     = 1;
  localparam int DEF_MAX_CORE_STREAK = 4;

  // Bits needed to hold 0..n-1, never less than 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Wait-state counter: cleared while idle, counts 0..WAIT_CYCLES.
// Ports: i_clk, i_rst, i_clr (load 0), i_en (count), o_tc (last cycle).
module dmem_arb_wait_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = cnt_width(WAIT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tc = (cnt_q == CW'(WAIT_CYCLES));

  // Saturates at the terminal count until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_en && !o_tc)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between core MEM stage and an
// external master. Ports: core req/we/addr/wdata in, stall/rdata/done out;
// ext req/we/addr/wdata in, rdata/ack out; memory en/we/addr/wdata out,
// r_data in.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int ADDR_W          = 32,
  parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES,
  parameter int MAX_CORE_STREAK = DEF_MAX_CORE_STREAK
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [WIDTH-1:0]  i_core_wdata,
  output logic              o_core_stall,
  output logic [WIDTH-1:0]  o_core_rdata,
  output logic              o_core_done,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [WIDTH-1:0]  i_ext_wdata,
  output logic [WIDTH-1:0]  o_ext_rdata,
  output logic              o_ext_ack,
  output logic              o_en,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_d_add,
  output logic [WIDTH-1:0]  o_w_data,
  input  logic [WIDTH-1:0]  i_r_data
);

  localparam int SW = cnt_width(MAX_CORE_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_CORE_STREAK);

  arb_state_t        state_q;
  logic              en_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [WIDTH-1:0]  core_rdata_q;
  logic [WIDTH-1:0]  ext_rdata_q;
  logic              core_done_q;
  logic              ext_ack_q;
  logic [SW-1:0]     streak_q;
  logic [SW-1:0]     streak_d;

  logic tc;
  logic pick_core;
  logic pick_ext;
  logic grant_core;
  logic grant_ext;

  dmem_arb_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(state_q == ARB_IDLE),
    .i_en (1'b1),
    .o_tc (tc)
  );

  // The winner is chosen on raw requests; a winner that just
  // completed (done/ack cycle) is held off for one cycle rather than
  // handing the slot to the loser, so the streak bound is what
  // decides when the external port gets in.
  always_comb begin
    pick_ext   = i_ext_req & (~i_core_req | (streak_q == SMAX));
    pick_core  = i_core_req & ~pick_ext;
    grant_core = pick_core & ~core_done_q;
    grant_ext  = pick_ext & ~ext_ack_q;
  end

  always_comb begin
    streak_d = '0;
    if (i_ext_req)
      streak_d = (streak_q == SMAX) ? streak_q : streak_q + SW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ARB_IDLE;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
      core_done_q  <= 1'b0;
      ext_ack_q    <= 1'b0;
      streak_q     <= '0;
    end else begin
      core_done_q <= 1'b0;
      ext_ack_q   <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (grant_core) begin
            state_q  <= ARB_CORE;
            en_q     <= 1'b1;
            we_q     <= i_core_we;
            addr_q   <= i_core_addr;
            wdata_q  <= i_core_wdata;
            streak_q <= streak_d;
          end else if (grant_ext) begin
            state_q  <= ARB_EXT;
            en_q     <= 1'b1;
            we_q     <= i_ext_we;
            addr_q   <= i_ext_addr;
            wdata_q  <= i_ext_wdata;
            streak_q <= '0;
          end
        end
        ARB_CORE: begin
          if (tc) begin
            state_q     <= ARB_IDLE;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            core_done_q <= 1'b1;
            if (!we_q)
              core_rdata_q <= i_r_data;
          end
        end
        ARB_EXT: begin
          if (tc) begin
            state_q   <= ARB_IDLE;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            ext_ack_q <= 1'b1;
            if (!we_q)
              ext_rdata_q <= i_r_data;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          en_q    <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_core_stall = i_core_req & ~core_done_q;
  assign o_core_rdata = core_rdata_q;
  assign o_core_done  = core_done_q;
  assign o_ext_rdata  = ext_rdata_q;
  assign o_ext_ack    = ext_ack_q;
  assign o_en         = en_q;
  assign o_we         = we_q;
  assign o_d_add      = addr_q;
  assign o_w_data     = wdata_q;

endmodule
